hilo_div_unit: RTL and testbench
================================

Name: hilo_div_unit

Overview:
- Responder side of the EX-stage HI/LO interface. Owns the architectural HI/LO pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests issued by the execute stage and commits results into HI/LO.
- Serves the 64-bit HI/LO value back to EX for MFHI/MFLO.
- Holds the pipeline through a busy handshake while a 32-iteration restoring divider runs.

Parameters:
- DIV_ITERS, 32, divider iterations; equals the operand width and is fixed for the 32-bit datapath.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  EX presents a HI/LO operation this cycle
- op  in  5  ALU control code (MULT/MULTU/DIV/DIVU/MTHI/MTLO from the shared defines)
- a  in  32  rs operand (dividend, multiplicand, or MTHI/MTLO data)
- b  in  32  rt operand
- flush  in  1  pipeline flush; cancels an in-flight divide
- busy  out  1  unit cannot accept a request; EX must stall
- done  out  1  one-cycle pulse when a divide commits
- hilo_o  out  64  {HI,LO} current architectural value

Behaviour:
- Reset (async, rst=1): HI=LO=0, state=IDLE, busy=0, done=0, hilo_o=0, iteration counter=0.
- A request is accepted when req_valid=1 and busy=0. Requests presented while busy=1 are ignored; EX holds them.
- A request whose op is not one of the six codes is ignored.
- MULT: {HI,LO} <= signed(a)*signed(b) at the next clk edge; 1-cycle latency; busy stays 0.
- MULTU: {HI,LO} <= a*b at the next clk edge; 1-cycle latency; busy stays 0.
- MTHI: HI <= a at the next edge; LO unchanged.
- MTLO: LO <= a at the next edge; HI unchanged.
- DIV/DIVU state machine:
  - IDLE: on accept, latch |a|, |b|, the quotient sign (a[31]^b[31]) and the remainder sign (a[31]). Signs apply to DIV only; DIVU uses raw values. Go to RUN with cnt=0.
  - RUN: one restoring step per cycle: shift the remainder/quotient pair, trial-subtract the divisor, set the quotient bit. cnt++. After DIV_ITERS steps go to FIN.
  - FIN: apply sign correction, write LO=quotient and HI=remainder, pulse done=1, return to IDLE.
- Divide timing:
  - Total latency is accept edge to HI/LO update = 34 cycles (1 latch + 32 RUN + 1 FIN).
  - busy=1 from the cycle after accept through FIN inclusive.
  - busy falls in the cycle where the new HI/LO value is visible.
- Divide by zero (b=0): runs the full latency, no trap. Result LO=32'hFFFF_FFFF, HI=a, for both signed and unsigned.
- Signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF, DIV): LO=32'h8000_0000, HI=0.
- flush:
  - During RUN/FIN: abort, return to IDLE next edge. HI/LO are unchanged, no done pulse, busy=0.
  - When coinciding with an accept: the request is dropped.
- The FIN commit has priority over nothing else: no request can be accepted while busy, so there is no write conflict.
- hilo_o is a registered output (HI/LO flops). An update becomes visible the cycle after the write edge.
- Reset asserted mid-divide clears everything immediately; the partial result is discarded.

Optional Feature:
- HILO_BYPASS_EN defined: hilo_o is combinationally forwarded with the value being written this cycle (MULT/MULTU/MTHI/MTLO accept, or divide FIN). MFHI/MFLO in the same cycle then see the new value.
- HILO_BYPASS_EN undefined: hilo_o is the register output only. EX-side M/W forwarding covers the hazard.

Decomposition:
- Shared defines/package: add DIV_CONTROL and DIVU_CONTROL next to the existing MULT/MULTU/MTHI/MTLO codes. Add state encodings DIV_IDLE, DIV_RUN, DIV_FIN. Add DIV_ITERS.
- One natural sub-module, div_core: the unsigned restoring divider with start/abort/valid handshake and a 64-bit {rem,quot} output.
- The sign handling, MULT logic, and HI/LO registers stay in the top.

Test Plan:
- Reset mid-divide: assert rst at cycle 10 of DIV -> hilo_o=0 and busy=0 immediately; no done pulse.
- MULT a=32'hFFFF_FFFE (-2), b=3 -> next cycle hilo_o=64'hFFFF_FFFF_FFFF_FFFA; busy never rises. MULTU with the same operands -> hilo_o=64'h0000_0002_FFFF_FFFA.
- DIV a=-7 (32'hFFFF_FFF9), b=2 -> busy high for 33 cycles, done pulse; LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- Divide by zero: DIVU a=32'h1234_5678, b=0 -> LO=32'hFFFF_FFFF, HI=32'h1234_5678 after 34 cycles. Signed overflow case -> LO=32'h8000_0000, HI=0.
- flush at cycle 15 of DIV, after prior MTHI 32'hAAAA_AAAA / MTLO 32'h5555_5555 -> hilo_o stays 64'hAAAA_AAAA_5555_5555, busy=0 next cycle, no done.
- Request held while busy: MTLO presented with req_valid during a DIV -> ignored until busy falls. The re-presented MTLO then overwrites LO in the following cycle.

Source files
------------

// File: rtl/hilo_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit_pkg
// Description : Shared ALU control codes, divider state encoding and helpers
//               for the HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_div_unit_pkg;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS) + 1;

    localparam logic [4:0] MULT_CONTROL  = 5'b01010;
    localparam logic [4:0] MULTU_CONTROL = 5'b01011;
    localparam logic [4:0] DIV_CONTROL   = 5'b01100;
    localparam logic [4:0] DIVU_CONTROL  = 5'b01101;
    localparam logic [4:0] MTHI_CONTROL  = 5'b01110;
    localparam logic [4:0] MTLO_CONTROL  = 5'b01111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_div_unit_div_core.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit_div_core
// Description : Unsigned 32-bit restoring divider, one quotient bit per cycle,
//               start/abort/valid handshake, result = {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit_div_core
    import hilo_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        valid,
    output logic [63:0] result
);

    div_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_rem;
    logic [31:0]        r_quot;
    logic [31:0]        r_dvsr;

    logic [32:0]        w_shift;
    logic [31:0]        w_sub;
    logic               w_fits;

    // Remainder < divisor always holds, so the 32-bit wrapped difference is exact.
    assign w_shift = {r_rem, r_quot[31]};
    assign w_fits  = (w_shift >= {1'b0, r_dvsr});
    assign w_sub   = w_shift[31:0] - r_dvsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_dvsr  <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start && !abort) begin
                        r_rem   <= '0;
                        r_quot  <= dividend;
                        r_dvsr  <= divisor;
                        r_cnt   <= '0;
                        r_state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    if (abort) begin
                        r_state <= DIV_IDLE;
                    end else begin
                        r_rem  <= w_fits ? w_sub : w_shift[31:0];
                        r_quot <= {r_quot[30:0], w_fits};
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
                            r_state <= DIV_FIN;
                        end
                    end
                end
                DIV_FIN: begin
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != DIV_IDLE);
    assign valid  = (r_state == DIV_FIN);
    assign result = {r_rem, r_quot};

endmodule
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit
// Description : HI/LO owner for the EX stage: MULT/MULTU/MTHI/MTLO in one
//               cycle, DIV/DIVU through a multi-cycle divider with busy stall.
//               Optional macro HILO_BYPASS_EN forwards the value being written.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit
    import hilo_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [63:0] hilo_o
);

    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_done;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_b_zero;

    logic               w_accept;
    logic               w_is_div;
    logic               w_signed;
    logic [31:0]        w_dvd;
    logic [31:0]        w_dvs;
    logic               w_core_busy;
    logic               w_core_valid;
    logic [63:0]        w_core_result;
    logic               w_commit;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;
    logic [31:0]        w_div_lo;
    logic [31:0]        w_div_hi;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_hi_next;
    logic [31:0]        w_lo_next;

    assign w_accept = req_valid && !w_core_busy && !flush;
    assign w_is_div = (op == DIV_CONTROL) || (op == DIVU_CONTROL);
    assign w_signed = (op == DIV_CONTROL);
    assign w_dvd    = w_signed ? abs32(a) : a;
    assign w_dvs    = w_signed ? abs32(b) : b;

    hilo_div_unit_div_core u_div_core (
        .clk      (clk),
        .rst      (rst),
        .start    (w_accept && w_is_div),
        .abort    (flush),
        .dividend (w_dvd),
        .divisor  (w_dvs),
        .busy     (w_core_busy),
        .valid    (w_core_valid),
        .result   (w_core_result)
    );

    assign w_commit = w_core_valid && !flush;
    assign w_quot   = w_core_result[31:0];
    assign w_rem    = w_core_result[63:32];

    // Divide by zero leaves an all-ones quotient regardless of operand signs.
    assign w_div_lo = r_b_zero ? 32'hFFFF_FFFF : (r_q_neg ? (32'd0 - w_quot) : w_quot);
    assign w_div_hi = r_r_neg ? (32'd0 - w_rem) : w_rem;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    always_comb begin
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (w_commit) begin
            w_hi_next = w_div_hi;
            w_lo_next = w_div_lo;
        end else if (w_accept) begin
            case (op)
                MULT_CONTROL:  {w_hi_next, w_lo_next} = w_prod_s;
                MULTU_CONTROL: {w_hi_next, w_lo_next} = w_prod_u;
                MTHI_CONTROL:  w_hi_next = a;
                MTLO_CONTROL:  w_lo_next = a;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_b_zero <= 1'b0;
        end else begin
            r_hi   <= w_hi_next;
            r_lo   <= w_lo_next;
            r_done <= w_commit;
            if (w_accept && w_is_div) begin
                r_q_neg  <= w_signed && (a[31] ^ b[31]);
                r_r_neg  <= w_signed && a[31];
                r_b_zero <= (b == 32'd0);
            end
        end
    end

    assign busy = w_core_busy;
    assign done = r_done;

`ifdef HILO_BYPASS_EN
    assign hilo_o = {w_hi_next, w_lo_next};
`else
    assign hilo_o = {r_hi, r_lo};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_div_unit
// Description : Self-checking bench for hilo_div_unit against an arithmetic
//               reference model of the HI/LO operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_div_unit;
    import hilo_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [63:0] hilo_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    hilo_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hilo_o    (hilo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        logic [63:0] u;
        case (o)
            MULT_CONTROL:  begin p = longint'($signed(x)) * longint'($signed(y)); {exp_hi, exp_lo} = p; end
            MULTU_CONTROL: begin u = {32'd0, x} * {32'd0, y}; {exp_hi, exp_lo} = u; end
            DIV_CONTROL:   {exp_hi, exp_lo} = ref_div(1'b1, x, y);
            DIVU_CONTROL:  {exp_hi, exp_lo} = ref_div(1'b0, x, y);
            MTHI_CONTROL:  exp_hi = x;
            MTLO_CONTROL:  exp_lo = x;
            default:       ;
        endcase
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        req_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Counts busy cycles until busy falls, bounded so a stuck unit cannot hang the run.
    task automatic wait_div(output int bcyc, output int dearly);
        bcyc = 0; dearly = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy !== 1'b1) break;
            bcyc++;
            if (done === 1'b1) dearly++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int bcyc, dearly;
        issue(o, x, y);
        model(o, x, y);
        if (o == DIV_CONTROL || o == DIVU_CONTROL) begin
            wait_div(bcyc, dearly);
            chk({tag, "_busy_cycles"}, 64'(bcyc), 64'd33);
            chk({tag, "_done_early"}, 64'(dearly), 64'd0);
            chk({tag, "_done"}, {63'd0, done}, 64'd1);
        end else begin
            chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        end
        chk({tag, "_hilo"}, hilo_o, {exp_hi, exp_lo});
    endtask

    initial begin
        int bcyc, dearly, dcnt;
        logic [4:0]  ops [7];
        logic [4:0]  o;
        logic [31:0] x, y;

        ops = '{MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL,
                MTHI_CONTROL, MTLO_CONTROL, 5'd3};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_hilo", hilo_o, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);

        do_op("mult_neg", MULT_CONTROL, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_abs", hilo_o, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op("multu", MULTU_CONTROL, 32'hFFFF_FFFE, 32'd3);
        chk("multu_abs", hilo_o, 64'h0000_0002_FFFF_FFFA);

        do_op("div_m7_2", DIV_CONTROL, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_abs", hilo_o, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu_100_7", DIVU_CONTROL, 32'd100, 32'd7);
        chk("divu_100_7_abs", hilo_o, 64'h0000_0002_0000_000E);
        do_op("divu_zero", DIVU_CONTROL, 32'h1234_5678, 32'd0);
        chk("divu_zero_abs", hilo_o, 64'h1234_5678_FFFF_FFFF);
        do_op("div_ovf", DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_abs", hilo_o, 64'h0000_0000_8000_0000);
        do_op("div_zero_neg", DIV_CONTROL, 32'hF000_0123, 32'd0);
        do_op("bad_op", 5'd3, 32'hDEAD_BEEF, 32'd5);

        // Flush coinciding with an accept drops the request.
        flush = 1'b1;
        issue(MULTU_CONTROL, 32'd7, 32'd9);
        flush = 1'b0;
        chk("flush_drop_hilo", hilo_o, {exp_hi, exp_lo});

        for (int n = 0; n < 24; n++) begin
            o = ops[$urandom_range(0, 6)];
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 20));
                2:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: y = $urandom;
            endcase
            do_op($sformatf("rnd%0d_op%0d", n, o), o, x, y);
        end

        // Flush during RUN leaves HI/LO untouched and never pulses done.
        do_op("mthi", MTHI_CONTROL, 32'hAAAA_AAAA, 32'd0);
        do_op("mtlo", MTLO_CONTROL, 32'h5555_5555, 32'd0);
        issue(DIV_CONTROL, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hilo", hilo_o, 64'hAAAA_AAAA_5555_5555);
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) dcnt++;
            @(posedge clk); #1;
        end
        chk("flush_no_done", 64'(dcnt), 64'd0);
        chk("flush_hilo_late", hilo_o, 64'hAAAA_AAAA_5555_5555);

        // MTLO held during a divide is ignored until busy falls, then applied.
        issue(DIVU_CONTROL, 32'd1_000_003, 32'd10);
        model(DIVU_CONTROL, 32'd1_000_003, 32'd10);
        req_valid = 1'b1; op = MTLO_CONTROL; a = 32'hC0DE_0001; b = 32'd0;
        wait_div(bcyc, dearly);
        chk("held_busy_cycles", 64'(bcyc), 64'd33);
        chk("held_div_hilo", hilo_o, {exp_hi, exp_lo});
        chk("held_done", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        model(MTLO_CONTROL, 32'hC0DE_0001, 32'd0);
        chk("held_mtlo_hilo", hilo_o, {exp_hi, exp_lo});
        chk("held_done_clear", {63'd0, done}, 64'd0);

        // Asynchronous reset in the middle of a divide.
        issue(DIV_CONTROL, 32'hFFFF_0000, 32'd77);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_hilo", hilo_o, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1 || busy === 1'b1) dcnt++;
            @(posedge clk); #1;
        end
        chk("rst_mid_quiet", 64'(dcnt), 64'd0);
        chk("rst_mid_hilo_late", hilo_o, 64'd0);

        do_op("post_rst_div", DIV_CONTROL, 32'd45, 32'hFFFF_FFFA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
